// File: rtl/isolde_vli_pkg.sv
// Shared types and header length decode for the ISOLDE variable-length instruction assembler.
package isolde_vli_pkg;

    localparam logic [6:0]  OPCODE_CUSTOM0 = 7'h0B;
    localparam logic [6:0]  OPCODE_CUSTOM1 = 7'h2B;
    localparam int unsigned LEN_W          = 4;

    typedef enum logic [1:0] {
        OPC_INVALID = 2'd0,
        OPC_CUSTOM0 = 2'd1,
        OPC_CUSTOM1 = 2'd2
    } isolde_vli_opcode_e;

    typedef struct packed {
        logic               legal;
        logic [LEN_W-1:0]   len;
        isolde_vli_opcode_e opc;
    } isolde_vli_dec_t;

    // Header decode: custom-0/1 opcodes carry length-1 in f3; everything else is rejected.
    function automatic isolde_vli_dec_t isolde_vli_decode_len(input logic [31:0] word,
                                                              input int unsigned max_words);
        isolde_vli_dec_t d;
        d.legal = 1'b0;
        d.len   = '0;
        d.opc   = OPC_INVALID;
        if (word[1:0] == 2'b11) begin
            if (word[6:0] == OPCODE_CUSTOM0) begin
                d.opc = OPC_CUSTOM0;
            end else if (word[6:0] == OPCODE_CUSTOM1) begin
                d.opc = OPC_CUSTOM1;
            end
            d.len   = LEN_W'(word[14:12]) + LEN_W'(1);
            d.legal = (d.opc != OPC_INVALID) && (32'(d.len) <= max_words);
        end
        if (!d.legal) begin
            d.len = '0;
            d.opc = OPC_INVALID;
        end
        return d;
    endfunction

endpackage

// File: rtl/isolde_vli_bundle_reg.sv
// One bundle slot: instruction words, word count and opcode class with valid/ready hold.
module isolde_vli_bundle_reg
    import isolde_vli_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 5,
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned CNT_W     = 3
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  logic                          load_i,
    input  logic [MAX_WORDS*WORD_W-1:0]   instr_i,
    input  logic [CNT_W-1:0]              words_i,
    input  isolde_vli_opcode_e            opc_i,
    input  logic                          ready_i,
    output logic                          valid_o,
    output logic [MAX_WORDS*WORD_W-1:0]   instr_o,
    output logic [CNT_W-1:0]              words_o,
    output isolde_vli_opcode_e            opc_o
);

    logic                        valid_q;
    logic [MAX_WORDS*WORD_W-1:0] instr_q;
    logic [CNT_W-1:0]            words_q;
    isolde_vli_opcode_e          opc_q;

    // Slot register: flush empties it, a load fills it, a handshake frees it; payload held otherwise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            words_q <= '0;
            opc_q   <= OPC_INVALID;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            words_q <= words_i;
            opc_q   <= opc_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign words_o = words_q;
    assign opc_o   = opc_q;

endmodule

// File: rtl/isolde_vli_assembler.sv
// Assembles 1..MAX_WORDS-word ISOLDE custom instructions from a word stream into one bundle.
// Optional build macro: ISOLDE_VLI_SKID_EN adds an assembly slot so collection continues
// while the output bundle is held.
module isolde_vli_assembler
    import isolde_vli_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 5,
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned CNT_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [WORD_W-1:0]             in_word_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [MAX_WORDS*WORD_W-1:0]   out_instr_o,
    output logic [CNT_W-1:0]              out_words_o,
    output isolde_vli_opcode_e            out_opcode_o,
    output logic                          illegal_o,
    output logic                          busy_o
);

    localparam int unsigned BW = MAX_WORDS * WORD_W;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_EMIT    = 2'd2
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   target_q;
    isolde_vli_opcode_e opc_q;
    logic [BW-1:0]      asm_q;
    logic               illegal_q;

    isolde_vli_dec_t    dec_c;
    logic               accept_c;
    logic               last_c;
    logic               complete_c;
    logic               enter_emit_c;
    logic               leave_emit_c;
    logic [BW-1:0]      new_instr_c;
    logic [CNT_W-1:0]   new_words_c;
    isolde_vli_opcode_e new_opc_c;

    // Header decode, word acceptance and instruction completion
    assign dec_c      = isolde_vli_decode_len(32'(in_word_i), MAX_WORDS);
    assign in_ready_o = rst_ni && !flush_i && (state_q != S_EMIT);
    assign accept_c   = in_valid_i && in_ready_o;
    assign last_c     = (count_q + CNT_W'(1)) == target_q;
    assign complete_c = accept_c &&
                        (((state_q == S_IDLE) && dec_c.legal && (dec_c.len == LEN_W'(1))) ||
                         ((state_q == S_COLLECT) && last_c));

    // Completed bundle as it will look once the word being accepted is merged in
    always_comb begin
        new_instr_c = asm_q;
        new_words_c = target_q;
        new_opc_c   = opc_q;
        if (state_q == S_IDLE) begin
            new_instr_c = BW'(in_word_i);
            new_words_c = CNT_W'(1);
            new_opc_c   = dec_c.opc;
        end else begin
            new_instr_c[32'(count_q)*WORD_W +: WORD_W] = in_word_i;
        end
    end

    // Collection FSM: header capture, payload stores, hand-off to the bundle slot(s)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            target_q  <= '0;
            opc_q     <= OPC_INVALID;
            asm_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            if (flush_i) begin
                state_q <= S_IDLE;
                count_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (accept_c) begin
                            if (!dec_c.legal) begin
                                illegal_q <= 1'b1;
                            end else begin
                                asm_q    <= BW'(in_word_i);
                                opc_q    <= dec_c.opc;
                                target_q <= CNT_W'(dec_c.len);
                                if (complete_c) begin
                                    count_q <= '0;
                                    state_q <= enter_emit_c ? S_EMIT : S_IDLE;
                                end else begin
                                    count_q <= CNT_W'(1);
                                    state_q <= S_COLLECT;
                                end
                            end
                        end
                    end
                    S_COLLECT: begin
                        if (accept_c) begin
                            asm_q[32'(count_q)*WORD_W +: WORD_W] <= in_word_i;
                            if (complete_c) begin
                                count_q <= '0;
                                state_q <= enter_emit_c ? S_EMIT : S_IDLE;
                            end else begin
                                count_q <= count_q + CNT_W'(1);
                            end
                        end
                    end
                    S_EMIT: begin
                        if (leave_emit_c) begin
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

`ifdef ISOLDE_VLI_SKID_EN
    logic               out_free_c;
    logic               out_load_c;
    logic               skid_valid_c;
    logic [BW-1:0]      skid_instr_c;
    logic [CNT_W-1:0]   skid_words_c;
    isolde_vli_opcode_e skid_opc_c;

    // Output slot is free now or is being freed by this cycle's handshake
    assign out_free_c   = !out_valid_o || out_ready_i;
    assign enter_emit_c = !out_free_c;
    assign leave_emit_c = out_free_c;
    assign out_load_c   = !flush_i && out_free_c && (skid_valid_c || complete_c);

    isolde_vli_bundle_reg #(
        .MAX_WORDS (MAX_WORDS),
        .WORD_W    (WORD_W),
        .CNT_W     (CNT_W)
    ) u_skid (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .load_i  (complete_c && !out_free_c),
        .instr_i (new_instr_c),
        .words_i (new_words_c),
        .opc_i   (new_opc_c),
        .ready_i (out_free_c),
        .valid_o (skid_valid_c),
        .instr_o (skid_instr_c),
        .words_o (skid_words_c),
        .opc_o   (skid_opc_c)
    );

    isolde_vli_bundle_reg #(
        .MAX_WORDS (MAX_WORDS),
        .WORD_W    (WORD_W),
        .CNT_W     (CNT_W)
    ) u_out (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .load_i  (out_load_c),
        .instr_i (skid_valid_c ? skid_instr_c : new_instr_c),
        .words_i (skid_valid_c ? skid_words_c : new_words_c),
        .opc_i   (skid_valid_c ? skid_opc_c : new_opc_c),
        .ready_i (out_ready_i),
        .valid_o (out_valid_o),
        .instr_o (out_instr_o),
        .words_o (out_words_o),
        .opc_o   (out_opcode_o)
    );
`else
    // Single slot: EMIT lasts exactly as long as the output bundle is pending
    assign enter_emit_c = 1'b1;
    assign leave_emit_c = out_valid_o && out_ready_i;

    isolde_vli_bundle_reg #(
        .MAX_WORDS (MAX_WORDS),
        .WORD_W    (WORD_W),
        .CNT_W     (CNT_W)
    ) u_out (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .load_i  (complete_c),
        .instr_i (new_instr_c),
        .words_i (new_words_c),
        .opc_i   (new_opc_c),
        .ready_i (out_ready_i),
        .valid_o (out_valid_o),
        .instr_o (out_instr_o),
        .words_o (out_words_o),
        .opc_o   (out_opcode_o)
    );
`endif

    assign illegal_o = illegal_q;
    assign busy_o    = (state_q != S_IDLE) || out_valid_o;

endmodule

// File: tb/tb_isolde_vli_assembler.sv
// Self-checking bench for isolde_vli_assembler: transaction model plus directed literal checks.
module tb_isolde_vli_assembler;
    import isolde_vli_pkg::*;

    localparam int unsigned MAX_WORDS = 5;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned CNT_W     = 3;
    localparam int unsigned BW        = MAX_WORDS * WORD_W;
    localparam int unsigned CW        = 256;
`ifdef ISOLDE_VLI_SKID_EN
    localparam int SLOTS = 2;
`else
    localparam int SLOTS = 1;
`endif

    logic                 clk_i;
    logic                 rst_ni;
    logic                 flush_i;
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [WORD_W-1:0]    in_word_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [BW-1:0]        out_instr_o;
    logic [CNT_W-1:0]     out_words_o;
    isolde_vli_opcode_e   out_opcode_o;
    logic                 illegal_o;
    logic                 busy_o;

    int tests_run = 0;
    int tests_failed = 0;

    isolde_vli_assembler #(
        .MAX_WORDS (MAX_WORDS),
        .WORD_W    (WORD_W),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_word_i    (in_word_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_instr_o  (out_instr_o),
        .out_words_o  (out_words_o),
        .out_opcode_o (out_opcode_o),
        .illegal_o    (illegal_o),
        .busy_o       (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [BW-1:0]      instr;
        int                 words;
        isolde_vli_opcode_e opc;
    } bundle_t;

    bundle_t            exp_q[$];
    bit                 m_active;
    int                 m_len;
    int                 m_cnt;
    logic [BW-1:0]      m_instr;
    isolde_vli_opcode_e m_opc;
    bit                 ill_exp;

    // Instruction length from header rules; 0 means the header is rejected
    function automatic int model_len(input logic [WORD_W-1:0] w);
        int n;
        if (w[1:0] != 2'b11) return 0;
        if (w[6:0] != 7'h0B && w[6:0] != 7'h2B) return 0;
        n = int'(w[14:12]) + 1;
        return (n > int'(MAX_WORDS)) ? 0 : n;
    endfunction

    function automatic void model_finish();
        bundle_t b;
        b.instr = m_instr;
        b.words = m_len;
        b.opc   = m_opc;
        exp_q.push_back(b);
        m_active = 1'b0;
    endfunction

    function automatic void model_push(input logic [WORD_W-1:0] w);
        int n;
        if (!m_active) begin
            n = model_len(w);
            if (n == 0) begin
                ill_exp = 1'b1;
            end else begin
                m_instr  = BW'(w);
                m_cnt    = 1;
                m_len    = n;
                m_opc    = (w[6:0] == 7'h0B) ? OPC_CUSTOM0 : OPC_CUSTOM1;
                m_active = 1'b1;
                if (n == 1) model_finish();
            end
        end else begin
            m_instr[m_cnt*WORD_W +: WORD_W] = w;
            m_cnt++;
            if (m_cnt == m_len) model_finish();
        end
    endfunction

    // Per-cycle compare against the model, then advance the model by this edge's events
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            exp_q.delete();
            m_active = 1'b0;
            ill_exp  = 1'b0;
        end else begin
            check("out_valid", CW'(out_valid_o), CW'(exp_q.size() != 0));
            check("busy", CW'(busy_o), CW'(m_active || exp_q.size() != 0));
            check("in_ready", CW'(in_ready_o), CW'(!flush_i && exp_q.size() < SLOTS));
            check("illegal", CW'(illegal_o), CW'(ill_exp));
            ill_exp = 1'b0;
            if (out_valid_o && exp_q.size() != 0) begin
                check("bundle_instr", CW'(out_instr_o), CW'(exp_q[0].instr));
                check("bundle_words", CW'(out_words_o), CW'(exp_q[0].words));
                check("bundle_opc", CW'(out_opcode_o), CW'(exp_q[0].opc));
                if (out_ready_i) void'(exp_q.pop_front());
            end
            if (flush_i) begin
                exp_q.delete();
                m_active = 1'b0;
            end else if (in_valid_i && in_ready_o) begin
                model_push(in_word_i);
            end
        end
    end

    // ---------------- stimulus ----------------
    // Present one word and hold it until accepted; returns #1 after the accepting edge
    task automatic send(input logic [WORD_W-1:0] w);
        bit acc;
        acc = 1'b0;
        in_valid_i = 1'b1;
        in_word_i  = w;
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge clk_i);
            acc = in_ready_o;
            @(posedge clk_i);
            #1;
        end
        in_valid_i = 1'b0;
        if (!acc) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_timeout: word %0h not accepted, ready %0b", w, in_ready_o);
        end
    endtask

    task automatic cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready_i = 1'b1;
        while (busy_o && n < 30) begin
            cycle();
            n++;
        end
        check("drain_idle", CW'(busy_o), CW'(0));
    endtask

    logic [7:0] rdy_pat;

    initial begin
        rst_ni      = 1'b0;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        in_word_i   = '0;
        out_ready_i = 1'b1;
        #12;
        // reset values
        check("rst_in_ready", CW'(in_ready_o), CW'(0));
        check("rst_out_valid", CW'(out_valid_o), CW'(0));
        check("rst_illegal", CW'(illegal_o), CW'(0));
        check("rst_busy", CW'(busy_o), CW'(0));
        check("rst_instr", CW'(out_instr_o), CW'(0));
        check("rst_words", CW'(out_words_o), CW'(0));
        check("rst_opc", CW'(out_opcode_o), CW'(OPC_INVALID));
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        cycle();

        // 1-word custom-0 instruction
        send(32'h0000000B);
        check("t1_valid", CW'(out_valid_o), CW'(1));
        check("t1_words", CW'(out_words_o), CW'(1));
        check("t1_opc", CW'(out_opcode_o), CW'(OPC_CUSTOM0));
        check("t1_instr", CW'(out_instr_o), CW'(32'h0000000B));
        cycle();
        check("t1_done", CW'(out_valid_o), CW'(0));

        // 5-word custom-1 instruction, one word per cycle
        send(32'h0000402B);
        send(32'h000000A1);
        send(32'h000000A2);
        send(32'h000000A3);
        check("t2_not_yet", CW'(out_valid_o), CW'(0));
        send(32'h000000A4);
        check("t2_valid", CW'(out_valid_o), CW'(1));
        check("t2_words", CW'(out_words_o), CW'(5));
        check("t2_opc", CW'(out_opcode_o), CW'(OPC_CUSTOM1));
        check("t2_instr", CW'(out_instr_o),
              CW'(160'h000000A4_000000A3_000000A2_000000A1_0000402B));
        cycle();

        // Rejected headers: too long, length 6, not 32-bit encoding, foreign opcode
        send(32'h0000700B);
        check("t3_illegal", CW'(illegal_o), CW'(1));
        check("t3_ready", CW'(in_ready_o), CW'(1));
        check("t3_no_valid", CW'(out_valid_o), CW'(0));
        cycle();
        check("t3_pulse_end", CW'(illegal_o), CW'(0));
        send(32'h0000500B);
        check("t3_len6", CW'(illegal_o), CW'(1));
        send(32'h00000008);
        check("t3_lowbits", CW'(illegal_o), CW'(1));
        send(32'h00000033);
        check("t3_opcode", CW'(illegal_o), CW'(1));
        cycle();

        // Flush mid-collection with a word offered in the flush cycle
        send(32'h0000200B);
        send(32'h00000011);
        flush_i    = 1'b1;
        in_valid_i = 1'b1;
        in_word_i  = 32'h00000022;
        #1;
        check("t4_flush_ready", CW'(in_ready_o), CW'(0));
        @(posedge clk_i);
        #1;
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        check("t4_busy", CW'(busy_o), CW'(0));
        check("t4_valid", CW'(out_valid_o), CW'(0));
        send(32'h0000000B);
        check("t4_words", CW'(out_words_o), CW'(1));
        check("t4_instr", CW'(out_instr_o), CW'(32'h0000000B));
        cycle();

        // Held bundle under backpressure with a header waiting on the input
        out_ready_i = 1'b0;
        send(32'h0000100B);
        send(32'h000000B1);
        in_valid_i = 1'b1;
        in_word_i  = 32'h0000000B;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("t5_hold_valid", CW'(out_valid_o), CW'(1));
            check("t5_hold_instr", CW'(out_instr_o), CW'(64'h000000B1_0000100B));
`ifndef ISOLDE_VLI_SKID_EN
            check("t5_stall", CW'(in_ready_o), CW'(0));
`endif
        end
        out_ready_i = 1'b1;
        send(32'h0000000B);
        drain();

        // Async reset mid-collection (count = 2)
        send(32'h0000300B);
        send(32'h0000000A);
        #2 rst_ni = 1'b0;
        #1;
        check("t6_valid", CW'(out_valid_o), CW'(0));
        check("t6_busy", CW'(busy_o), CW'(0));
        check("t6_ready", CW'(in_ready_o), CW'(0));
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        send(32'h0000100B);
        send(32'h000000C1);
        check("t6_words", CW'(out_words_o), CW'(2));
        check("t6_instr", CW'(out_instr_o), CW'(64'h000000C1_0000100B));
        check("t6_opc", CW'(out_opcode_o), CW'(OPC_CUSTOM0));
        cycle();

        // Mixed stream against a toggling exec ready
        rdy_pat = 8'b1011_0010;
        fork
            begin
                send(32'h0000000B);
                send(32'h0000002B);
                send(32'h0000100B);
                send(32'h000000D1);
                send(32'h0000000B);
                send(32'h12345678);
                send(32'h0000202B);
                send(32'h000000E1);
                send(32'h000000E2);
                send(32'h0000600B);
                send(32'h0000002B);
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    @(posedge clk_i);
                    #1 out_ready_i = rdy_pat[i % 8];
                end
            end
        join
        drain();
        check("model_empty", CW'(exp_q.size()), CW'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", tests_failed);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/isolde_vli_assembler.md
Name: isolde_vli_assembler

Overview:
- Parametrised successor to the ISOLDE custom-instruction decoder.
- Accepts a stream of 32-bit instruction words over valid/ready and decodes the instruction length from the header word.
- Assembles a complete variable-length instruction of 1..MAX_WORDS words and hands it as one bundle to the ISOLDE exec stage over valid/ready.
- Sits between the IF-ID pipeline registers and the ISOLDE exec unit, replacing the fixed 5-word batch interface.

Parameters:
- MAX_WORDS, 5, maximum instruction length in words (2..8).
- WORD_W, 32, instruction word width.
- CNT_W, $clog2(MAX_WORDS+1), width of the word counter and of words_o.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  discard partial and pending instructions
- in_valid_i  in  1  instruction word valid
- in_ready_o  out  1  word accepted when in_valid_i && in_ready_o
- in_word_i  in  WORD_W  instruction word
- out_valid_o  out  1  assembled bundle valid
- out_ready_i  in  1  exec accepts the bundle
- out_instr_o  out  MAX_WORDS*WORD_W  bundle; word k at bits [k*WORD_W +: WORD_W], word 0 = header
- out_words_o  out  CNT_W  number of valid words in the bundle (1..MAX_WORDS)
- out_opcode_o  out  isolde_vli_opcode_e  decoded opcode class
- illegal_o  out  1  one-cycle pulse: header rejected
- busy_o  out  1  state != IDLE or out_valid_o

Behaviour:
- Reset (async, rst_ni low): state=IDLE, count=0; in_ready_o=0 during reset; out_valid_o=0, illegal_o=0, busy_o=0, out_instr_o=0, out_words_o=0, out_opcode_o=OPC_INVALID.
- Length decode is combinational on the header word (w[6:0]=opcode, w[14:12]=f3):
  - w[1:0]!=2'b11: illegal.
  - opcode 7'h0B (custom-0): len=f3+1, class OPC_CUSTOM0.
  - opcode 7'h2B (custom-1): len=f3+1, class OPC_CUSTOM1.
  - Any other opcode: illegal.
  - len>MAX_WORDS: illegal.
- FSM states: IDLE, COLLECT, EMIT.
- IDLE:
  - in_ready_o=1.
  - Legal header accepted with len==1: store word 0 and go to EMIT next cycle.
  - Legal header accepted with len>1: store word 0, set target=len, count=1, go to COLLECT.
  - Illegal header: word is consumed, illegal_o=1 for one cycle, stay in IDLE.
- COLLECT:
  - in_ready_o=1; each accepted word is stored at index count, then count++.
  - When count+1==target on acceptance, go to EMIT.
  - Payload words are never length-decoded.
- EMIT:
  - out_valid_o=1; out_* held stable while out_valid_o && !out_ready_i.
  - in_ready_o=0 (base build).
  - On out_ready_i: go to IDLE next cycle, out_valid_o=0.
- Latency: bundle valid the cycle after the last word is accepted; a 1-word instruction is valid the cycle after acceptance.
- Unused bundle words (index ≥ out_words_o) are zero.
- flush_i has priority over every other event:
  - in_ready_o=0 in the flush cycle; any in_valid_i word is dropped.
  - Next cycle: state=IDLE, count=0, out_valid_o=0, no illegal pulse.
  - A pending, not-yet-accepted bundle is discarded.
- out_valid_o && out_ready_i in the same cycle as flush_i: the handshake counts as completed (exec owns the bundle).
- Async reset mid-COLLECT or mid-EMIT: all partial state lost, outputs return to reset values.
- Backpressure: in_valid_i with in_ready_o=0 must not change any state.

Optional Feature:
- Macro: ISOLDE_VLI_SKID_EN.
- Defined:
  - Adds a second bundle register (output slot plus assembly slot).
  - Collection of the next instruction proceeds while the output slot is held.
  - in_ready_o drops only when the output slot is full and the assembly slot holds a complete bundle.
  - On out_ready_i the assembly slot moves to the output slot in the same cycle it is freed.
  - Sustained throughput: one 1-word instruction per cycle.
- Undefined: single-slot behaviour exactly as in Behaviour.

Decomposition:
- Package isolde_vli_pkg:
  - isolde_vli_opcode_e {OPC_INVALID, OPC_CUSTOM0, OPC_CUSTOM1}.
  - OPCODE_CUSTOM0=7'h0B, OPCODE_CUSTOM1=7'h2B.
  - Function isolde_vli_decode_len(word, max_words) returning {legal, len, class}.
- One natural sub-module: isolde_vli_bundle_reg (bundle + words + opcode storage with valid/ready hold), instantiated once, or twice under ISOLDE_VLI_SKID_EN.

Test Plan:
- Header 32'h0000000B (custom-0, f3=0) with out_ready_i=1 → out_valid_o one cycle later, out_words_o=1, out_opcode_o=OPC_CUSTOM0, words 1..4 zero.
- Header 32'h0000402B (f3=4, len 5) then words 32'hA1..32'hA4 at one per cycle → bundle {2B hdr, A1, A2, A3, A4}, out_words_o=5, valid the cycle after 32'hA4.
- Header 32'h00006000B... replace with 32'h0000700B (len 8 > MAX_WORDS=5) → illegal_o pulses one cycle, in_ready_o stays 1, no out_valid_o.
- Header 32'h0000200B (len 3), one payload word, then flush_i with in_valid_i=1 → dropped, IDLE, next header 32'h0000000B assembles cleanly with out_words_o=1.
- Bundle pending with out_ready_i=0 for 10 cycles → out_* stable, in_ready_o=0 (base) or collection continues then stalls (ISOLDE_VLI_SKID_EN).
- rst_ni asserted mid-COLLECT (count=2) → out_valid_o=0, busy_o=0 asynchronously; after release, a fresh len-2 instruction assembles correctly.
